// File: rtl/ray_dispatcher.sv
// Frame scheduler: raster-scans the display, issues pixels to idle ray units and retires
// finished colours to the framebuffer. Define RAY_DISPATCH_PERF_EN for the frame cycle counter.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 180
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

module ray_dispatcher #(
    parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
    parameter int H_BITS         = `H_BITS,
    parameter int V_BITS         = `V_BITS,
    parameter int NUM_UNITS      = 4,
    parameter int COORD_BITS     = 16,
    localparam int ADDR_BITS     = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT),
    localparam int VEC_BITS      = 3 * COORD_BITS
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    input  logic [VEC_BITS-1:0]           cam_pos_in,
    input  logic [VEC_BITS-1:0]           cam_forward_in,
    output logic [VEC_BITS-1:0]           ray_origin_out,
    output logic [VEC_BITS-1:0]           ray_direction_out,
    output logic [H_BITS-1:0]             hcount_out,
    output logic [V_BITS-1:0]             vcount_out,
    output logic [NUM_UNITS-1:0]          valid_out,
    input  logic [NUM_UNITS-1:0]          ready_in,
    input  logic [NUM_UNITS*H_BITS-1:0]   unit_hcount_in,
    input  logic [NUM_UNITS*V_BITS-1:0]   unit_vcount_in,
    input  logic [NUM_UNITS*4-1:0]        unit_color_in,
    output logic                          fb_we_out,
    output logic [ADDR_BITS-1:0]          fb_addr_out,
    output logic [3:0]                    fb_data_out,
    output logic                          busy_out,
    output logic                          frame_done_out,
    output logic [31:0]                   frame_cycles_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [H_BITS-1:0]    ras_h;
    logic [V_BITS-1:0]    ras_v;
    logic [NUM_UNITS-1:0] busy, busy_next;
    logic [NUM_UNITS-1:0] idle_vec, done_vec, issue_sel, retire_sel;
    logic                 issue_en, retire_en, last_col, last_pixel;
    logic [ADDR_BITS-1:0] retire_addr;
    logic [3:0]           retire_color;

    assign last_col   = (ras_h == H_BITS'(DISPLAY_WIDTH - 1));
    assign last_pixel = last_col && (ras_v == V_BITS'(DISPLAY_HEIGHT - 1));

    // Descending scan so the lowest-index candidate wins for both issue and retire.
    always_comb begin
        idle_vec     = ready_in & ~busy & ~valid_out;
        done_vec     = busy & ready_in & ~valid_out;
        issue_sel    = '0;
        retire_sel   = '0;
        retire_addr  = '0;
        retire_color = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (idle_vec[i]) begin
                issue_sel = NUM_UNITS'(1) << i;
            end
            if (done_vec[i]) begin
                retire_sel   = NUM_UNITS'(1) << i;
                retire_addr  = ADDR_BITS'(unit_vcount_in[i*V_BITS +: V_BITS])
                               * ADDR_BITS'(DISPLAY_WIDTH)
                               + ADDR_BITS'(unit_hcount_in[i*H_BITS +: H_BITS]);
                retire_color = unit_color_in[i*4 +: 4];
            end
        end
        issue_en  = (state == ISSUE) && (idle_vec != '0);
        retire_en = (done_vec != '0);
        busy_next = busy & ~retire_sel;
        if (issue_en) begin
            busy_next = busy_next | issue_sel;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_in) state_next = ISSUE;
            ISSUE:   if (issue_en && last_pixel) state_next = DRAIN;
            DRAIN:   if (busy == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= IDLE;
            ras_h             <= '0;
            ras_v             <= '0;
            busy              <= '0;
            valid_out         <= '0;
            hcount_out        <= '0;
            vcount_out        <= '0;
            ray_origin_out    <= '0;
            ray_direction_out <= '0;
            fb_we_out         <= 1'b0;
            fb_addr_out       <= '0;
            fb_data_out       <= '0;
        end else begin
            state     <= state_next;
            busy      <= busy_next;
            valid_out <= '0;
            fb_we_out <= 1'b0;
            if (state == IDLE && start_in) begin
                ray_origin_out    <= cam_pos_in;
                ray_direction_out <= cam_forward_in;
                ras_h             <= '0;
                ras_v             <= '0;
            end
            if (issue_en) begin
                valid_out  <= issue_sel;
                hcount_out <= ras_h;
                vcount_out <= ras_v;
                if (last_col) begin
                    ras_h <= '0;
                    ras_v <= ras_v + V_BITS'(1);
                end else begin
                    ras_h <= ras_h + H_BITS'(1);
                end
            end
            if (retire_en) begin
                fb_we_out   <= 1'b1;
                fb_addr_out <= retire_addr;
                fb_data_out <= retire_color;
            end
        end
    end

    assign busy_out       = (state != IDLE);
    assign frame_done_out = (state == DONE);

`ifdef RAY_DISPATCH_PERF_EN
    logic [31:0] cyc_cnt, cyc_inc, cyc_hold;

    // The DONE cycle itself is included in the published count.
    assign cyc_inc = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cyc_cnt  <= '0;
            cyc_hold <= '0;
        end else begin
            if (state == IDLE) begin
                if (start_in) begin
                    cyc_cnt <= '0;
                end
            end else begin
                cyc_cnt <= cyc_inc;
            end
            if (state == DONE) begin
                cyc_hold <= cyc_inc;
            end
        end
    end

    assign frame_cycles_out = cyc_hold;
`else
    assign frame_cycles_out = '0;
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher: W=4, H=2, two latency-modelled ray units.
module tb_ray_dispatcher;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [47:0] cam_pos, cam_fwd, ray_origin, ray_dir;
    logic [1:0]  hcount_out;
    logic        vcount_out;
    logic [1:0]  valid_out, ready_in, unit_en;
    logic [3:0]  unit_h;
    logic [1:0]  unit_v;
    logic [7:0]  unit_c;
    logic        fb_we;
    logic [2:0]  fb_addr;
    logic [3:0]  fb_data;
    logic        busy_out, frame_done;
    logic [31:0] frame_cycles;

    ray_dispatcher #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .H_BITS        (2),
        .V_BITS        (1),
        .NUM_UNITS     (2)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .start_in         (start),
        .cam_pos_in       (cam_pos),
        .cam_forward_in   (cam_fwd),
        .ray_origin_out   (ray_origin),
        .ray_direction_out(ray_dir),
        .hcount_out       (hcount_out),
        .vcount_out       (vcount_out),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .unit_hcount_in   (unit_h),
        .unit_vcount_in   (unit_v),
        .unit_color_in    (unit_c),
        .fb_we_out        (fb_we),
        .fb_addr_out      (fb_addr),
        .fb_data_out      (fb_data),
        .busy_out         (busy_out),
        .frame_done_out   (frame_done),
        .frame_cycles_out (frame_cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Unit models: drop ready after sampling valid, raise it again after lat[i] cycles.
    logic       mdl_rdy [2];
    int         mdl_cnt [2];
    logic [1:0] mdl_h   [2];
    logic       mdl_v   [2];
    int         lat     [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mdl_rdy[i] <= 1'b1;
                mdl_cnt[i] <= 0;
                mdl_h[i]   <= '0;
                mdl_v[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ready_in[i] && valid_out[i]) begin
                    mdl_rdy[i] <= 1'b0;
                    mdl_cnt[i] <= lat[i] - 1;
                    mdl_h[i]   <= hcount_out;
                    mdl_v[i]   <= vcount_out;
                end else if (!mdl_rdy[i]) begin
                    if (mdl_cnt[i] == 0) mdl_rdy[i] <= 1'b1;
                    else mdl_cnt[i] <= mdl_cnt[i] - 1;
                end
            end
        end
    end

    // Model colour for pixel address a is 15 - a.
    assign ready_in = {mdl_rdy[1] & unit_en[1], mdl_rdy[0] & unit_en[0]};
    assign unit_h   = {mdl_h[1], mdl_h[0]};
    assign unit_v   = {mdl_v[1], mdl_v[0]};
    assign unit_c   = {4'(15 - (int'(mdl_v[1]) * W + int'(mdl_h[1]))),
                       4'(15 - (int'(mdl_v[0]) * W + int'(mdl_h[0])))};

    int   cyc = 0;
    int   wr_addr[$];
    int   wr_data[$];
    int   wr_cyc[$];
    int   done_cnt = 0;
    int   vcnt = 0;
    int   busy_cyc = 0;
    int   viol = 0;
    logic pend [2];
    int   pend_addr [2];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fb_we) begin
            wr_addr.push_back(int'(fb_addr));
            wr_data.push_back(int'(fb_data));
            wr_cyc.push_back(cyc);
            for (int i = 0; i < 2; i++)
                if (pend[i] && pend_addr[i] == int'(fb_addr)) pend[i] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (valid_out[i]) begin
                if (pend[i]) viol++;
                pend[i]      = 1'b1;
                pend_addr[i] = int'(vcount_out) * W + int'(hcount_out);
                vcnt++;
            end
        end
        if (frame_done) done_cnt++;
        if (busy_out) busy_cyc++;
        if (rst) begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        busy_cyc = 0;
    endtask

    task automatic start_frame(input logic [47:0] pos, input logic [47:0] fwd);
        cam_pos = pos;
        cam_fwd = fwd;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_busy_after"}, busy_out, 0);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_writes"}, wr_addr.size(), 8);
        for (int i = 0; i < wr_addr.size() && i < 8; i++) begin
            check({tag, "_addr"}, wr_addr[i], i);
            check({tag, "_data"}, wr_data[i], 15 - i);
        end
    endtask

    localparam logic [47:0] POS_A = 48'h0001_0002_0003;
    localparam logic [47:0] FWD_A = 48'h0000_0000_7FFF;
    localparam logic [47:0] POS_B = 48'h1111_2222_3333;
    localparam logic [47:0] FWD_B = 48'h4444_5555_6666;
    localparam logic [47:0] POS_C = 48'hAAAA_BBBB_CCCC;

    initial begin
        int d0, v0;
        rst     = 1'b1;
        start   = 1'b0;
        cam_pos = '0;
        cam_fwd = '0;
        unit_en = 2'b11;
        lat[0]  = 3;
        lat[1]  = 3;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", valid_out, 0);
        check("rst_we", fb_we, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", frame_done, 0);
        check("rst_origin", ray_origin, 0);
        check("rst_cycles", frame_cycles, 0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: unit 1 held not-ready, unit 0 at L=3 (6-cycle pixel period, 50 busy cycles).
        unit_en = 2'b01;
        clear_log();
        d0 = done_cnt;
        start_frame(POS_A, FWD_A);
        wait_done("f1", d0);
        check_frame("f1");
        check("f1_origin", ray_origin, POS_A);
        check("f1_dir", ray_dir, FWD_A);
        check("f1_busy_cycles", busy_cyc, 50);
`ifdef RAY_DISPATCH_PERF_EN
        check("f1_frame_cycles", frame_cycles, 50);
`else
        check("f1_frame_cycles", frame_cycles, 0);
`endif

        // Frame 2: latencies chosen so both units complete in the same cycle; start pulsed mid-frame.
        unit_en = 2'b11;
        lat[0]  = 3;
        lat[1]  = 2;
        clear_log();
        viol = 0;
        d0 = done_cnt;
        start_frame(POS_B, FWD_B);
        repeat (8) @(negedge clk);
        cam_pos = POS_C;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done("f2", d0);
        check_frame("f2");
        if (wr_cyc.size() >= 2) check("f2_back_to_back", wr_cyc[1] - wr_cyc[0], 1);
        else check("f2_back_to_back", wr_cyc.size(), 2);
        check("f2_no_reissue", viol, 0);
        check("f2_origin", ray_origin, POS_B);
        check("f2_dir", ray_dir, FWD_B);

        // Frame 3: reset after three issues, then a clean frame.
        clear_log();
        v0 = vcnt;
        start_frame(POS_A, FWD_A);
        for (int n = 0; n < 200 && vcnt - v0 < 3; n++) @(negedge clk);
        check("f3_issues", vcnt - v0, 3);
        rst = 1'b1;
        #1;
        check("f3_rst_valid", valid_out, 0);
        check("f3_rst_we", fb_we, 0);
        check("f3_rst_busy", busy_out, 0);
        check("f3_rst_h", hcount_out, 0);
        check("f3_rst_origin", ray_origin, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        d0 = done_cnt;
        start_frame(POS_A, FWD_A);
        wait_done("f4", d0);
        check_frame("f4");

        // Frame 5: no ready units for 10 cycles in ISSUE; raster must hold at (0,0).
        unit_en = 2'b00;
        clear_log();
        d0 = done_cnt;
        start_frame(POS_B, FWD_B);
        v0 = vcnt;
        repeat (10) @(negedge clk);
        check("f5_stall_valid", vcnt - v0, 0);
        check("f5_stall_busy", busy_out, 1);
        unit_en = 2'b11;
        wait_done("f5", d0);
        check_frame("f5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
